letter_grid_buffer: RTL and testbench
=====================================

# letter_grid_buffer

Holds the ROWS×COLS grid of typed letters and, each pixel clock, tells the downstream `image_sprite` stage which letter to draw and where its tile sits. Keystrokes from the keyboard decoder arrive over a valid/ready handshake. Committed rows are reported on a one-cycle pulse to the game-logic block. The scan path is a fixed 2-cycle pipeline, and delayed `hcount`/`vcount` copies are provided so the sprite stage stays aligned with it.

## Interface
Parameters:
- `COLS`, 5, letters per row
- `ROWS`, 6, number of rows
- `ORIGIN_X`, 100, left pixel of column 0
- `ORIGIN_Y`, 50, top pixel of row 0
- `PITCH_X`, 42, horizontal tile pitch (38 px tile + 4 px gap)
- `PITCH_Y`, 49, vertical tile pitch (45 px tile + 4 px gap)

Ports:
- `pixel_clk_in`  in  1  pixel clock; the only clock
- `rst_n_in`  in  1  asynchronous, active-low reset
- `key_valid_in`  in  1  key code present
- `key_code_in`  in  5  key code: 1–26 = letter, 27 = backspace, 28 = enter, others = no-op
- `key_ready_out`  out  1  block can accept a key this cycle
- `clear_in`  in  1  one-cycle request to wipe the grid
- `hcount_in`  in  11  current pixel x
- `vcount_in`  in  10  current pixel y
- `hcount_out`  out  11  `hcount_in` delayed by 2 cycles
- `vcount_out`  out  10  `vcount_in` delayed by 2 cycles
- `letter_out`  out  5  letter for the tile under (`hcount_out`, `vcount_out`); 0 = blank
- `x_out`  out  11  tile left edge
- `y_out`  out  10  tile top edge
- `cursor_row_out`  out  3  row being edited
- `cursor_col_out`  out  3  next column to write
- `commit_valid_out`  out  1  one-cycle pulse: a row was committed
- `commit_word_out`  out  5·COLS  committed letters; column 0 in the LSBs
- `full_out`  out  1  all rows committed

## Operation
- Storage: ROWS·COLS cells of 5 bits each, one write port and one read port, read-first.
- FSM states:
  - **CLEAR**: writes 0 to cell index `clr_idx`, one cell per cycle. After cell ROWS·COLS−1 it moves to EDIT with cursor (0,0).
  - **EDIT**: `key_ready_out`=1. A key is accepted when `key_valid_in` && `key_ready_out`.
    - Letter with col<COLS: write the cell, then col+1.
    - Letter with col==COLS: consumed, no effect.
    - Backspace with col>0: col−1 and write 0 to that cell.
    - Backspace with col==0: consumed, no effect.
    - Enter with col==COLS: go to COMMIT.
    - Enter with col<COLS: consumed, no effect.
    - Code 0 or 29–31: consumed, no effect.
  - **COMMIT** (one cycle): `commit_word_out` is loaded from the row and `commit_valid_out` is asserted in the next cycle.
    - row<ROWS−1: row+1, col=0, go to EDIT.
    - row==ROWS−1: go to DONE.
  - **DONE**: `full_out`=1, `key_ready_out`=0. Keys are held off, not consumed.
- `clear_in` in any state: go to CLEAR with `clr_idx`=0, and the cursor resets to (0,0). In CLEAR, a further `clear_in` restarts the sweep. `clear_in` takes priority over a key accepted in the same cycle; that key is dropped.
- `key_ready_out`=0 in CLEAR, COMMIT and DONE.
- Scan:
  - `col = (hcount_in − ORIGIN_X) / PITCH_X`, computed by a comparator chain. No divider.
  - `row` is computed the same way from `vcount_in`, `ORIGIN_Y` and `PITCH_Y`.
  - Inside the grid rectangle: `letter_out` = cell value, `x_out` = ORIGIN_X + col·PITCH_X, `y_out` = ORIGIN_Y + row·PITCH_Y.
  - Outside the grid: `letter_out`, `x_out` and `y_out` are all 0.
  - Gap pixels belong to the tile on their left/top. The sprite stage's own bounds check renders them white.

## Timing
- Reset (`rst_n_in` low, asynchronous): state=CLEAR, `clr_idx`=0, cursor (0,0).
- Output values during reset: `key_ready_out`=0, `commit_valid_out`=0, `commit_word_out`=0, `full_out`=0, `letter_out`=0, `x_out`=0, `y_out`=0, `hcount_out`=0, `vcount_out`=0.
- After release, CLEAR takes ROWS·COLS cycles before `key_ready_out` rises.
- Reset asserted mid-sweep or mid-commit aborts immediately; no commit pulse is emitted.
- Scan latency: 2 cycles.
  - Stage 1 registers col, row, in-grid flag and tile origin.
  - Stage 2 registers the array read.
- A write to the cell being scanned in the same cycle shows the old value. The new value is visible from the next read.
- Accepted key to cursor update: 1 cycle. Enter to `commit_valid_out`: 2 cycles, high for exactly 1 cycle.
- `commit_word_out` holds its value until the next commit or reset.

## Structure
- Shared package `text_pkg`:
  - `LETTER_NONE`=0, `KEY_BACKSPACE`=27, `KEY_ENTER`=28
  - tile size constants 38 and 45, used by both this block and the sprite stage
  - FSM state enum `grid_state_t` {CLEAR, EDIT, COMMIT, DONE}
- Sub-module `letter_grid_scan`: the 2-stage pixel-to-tile pipeline, including the `hcount`/`vcount` delay line. It outputs the cell read index plus `x_out`/`y_out`. The cell array and FSM stay in the top level.

## Test plan
- Reset release: `key_ready_out` is 0 for 30 cycles, then 1. Every pixel in the grid scans to `letter_out`=0 and cursor reads (0,0).
- Type codes 3,1,20 (C,A,T): cursor col=3. Scan pixel (100,50) gives `letter_out`=3, `x_out`=100, `y_out`=50 two cycles later. Pixel (184,60) gives `letter_out`=20, `x_out`=184.
- Backspace at col 0 leaves col=0. Backspace at col 3 clears cell 2 and gives col=2.
- Type 5 letters, then Enter: `commit_valid_out` pulses 1 cycle, `commit_word_out` = the packed codes, cursor becomes (1,0). Enter at col=4 does nothing.
- Commit 6 rows: `full_out`=1, `key_ready_out`=0, and a held key stays unconsumed. `clear_in` then gives 30 CLEAR cycles, all cells 0, cursor (0,0), `full_out`=0.
- Pixel (90,40) outside the grid gives all-zero outputs. Pulse `rst_n_in` low mid-commit: no pulse is emitted and CLEAR restarts.

Source files
------------

// File: rtl/letter_grid_buffer_pkg.sv
// Shared text-rendering package.
// Purpose: key codes, tile geometry shared with the image_sprite stage,
//          and the grid-buffer state encoding.
// Contents: LETTER_NONE / KEY_BACKSPACE / KEY_ENTER codes, TILE_W / TILE_H,
//           grid_state_t, is_letter() helper.
package text_pkg;

    localparam logic [4:0] LETTER_NONE   = 5'd0;
    localparam logic [4:0] LETTER_LAST   = 5'd26;
    localparam logic [4:0] KEY_BACKSPACE = 5'd27;
    localparam logic [4:0] KEY_ENTER     = 5'd28;

    // Visible tile size; the pitch adds a 4-pixel gap on the right/bottom.
    localparam int TILE_W = 38;
    localparam int TILE_H = 45;

    typedef enum logic [1:0] {
        CLEAR,
        EDIT,
        COMMIT,
        DONE
    } grid_state_t;

    function automatic logic is_letter(input logic [4:0] code);
        return (code != LETTER_NONE) && (code <= LETTER_LAST);
    endfunction

endpackage

// File: rtl/letter_grid_buffer_if.sv
// Keystroke handshake between the keyboard decoder and the grid buffer.
// Signals: key_valid_in (code present), key_code_in (5-bit key code),
//          key_ready_out (grid buffer can take a key this cycle).
// Modports: master = keyboard decoder side, slave = grid buffer side.
interface letter_grid_buffer_if;
    logic       key_valid_in;
    logic [4:0] key_code_in;
    logic       key_ready_out;

    modport master (output key_valid_in, output key_code_in, input key_ready_out);
    modport slave  (input key_valid_in, input key_code_in, output key_ready_out);
endinterface

// File: rtl/letter_grid_buffer_scan.sv
// letter_grid_scan: 2-stage pixel-to-tile pipeline.
// Stage 1 maps (hcount_in, vcount_in) to a tile column/row with a chain of
// constant comparators, and registers the tile origin and in-grid flag.
// Stage 2 registers x_out/y_out alongside the parent's cell-array read.
// Ports: pixel_clk_in, rst_n_in; hcount_in/vcount_in pixel position;
//        rd_idx_out/in_grid_out stage-1 cell index and grid flag for the
//        parent's read port; x_out/y_out tile origin (0 outside the grid);
//        hcount_out/vcount_out positions delayed by 2 cycles.
module letter_grid_scan
    import text_pkg::*;
#(
    parameter int COLS     = 5,
    parameter int ROWS     = 6,
    parameter int ORIGIN_X = 100,
    parameter int ORIGIN_Y = 50,
    parameter int PITCH_X  = 42,
    parameter int PITCH_Y  = 49,
    parameter int IDX_W    = $clog2(COLS * ROWS)
) (
    input  logic             pixel_clk_in,
    input  logic             rst_n_in,
    input  logic [10:0]      hcount_in,
    input  logic [9:0]       vcount_in,
    output logic [IDX_W-1:0] rd_idx_out,
    output logic             in_grid_out,
    output logic [10:0]      x_out,
    output logic [9:0]       y_out,
    output logic [10:0]      hcount_out,
    output logic [9:0]       vcount_out
);

    // ge_x[k] is set when the pixel is at or right of the left edge of column k;
    // ge_x[COLS] marks the right edge of the grid (gap of the last column included).
    logic [COLS:0] ge_x;
    logic [ROWS:0] ge_y;

    genvar gi;
    generate
        for (gi = 0; gi <= COLS; gi++) begin : g_col_edge
            assign ge_x[gi] = (hcount_in >= 11'(ORIGIN_X + gi * PITCH_X));
        end
        for (gi = 0; gi <= ROWS; gi++) begin : g_row_edge
            assign ge_y[gi] = (vcount_in >= 10'(ORIGIN_Y + gi * PITCH_Y));
        end
    endgenerate

    logic [2:0]  col_c, row_c;
    logic [10:0] x_c;
    logic [9:0]  y_c;
    logic        in_grid_c;

    always_comb begin
        col_c = '0;
        row_c = '0;
        for (int i = 1; i < COLS; i++) begin
            if (ge_x[i]) col_c = 3'(i);
        end
        for (int i = 1; i < ROWS; i++) begin
            if (ge_y[i]) row_c = 3'(i);
        end
        x_c       = 11'(ORIGIN_X + int'(col_c) * PITCH_X);
        y_c       = 10'(ORIGIN_Y + int'(row_c) * PITCH_Y);
        in_grid_c = ge_x[0] && !ge_x[COLS] && ge_y[0] && !ge_y[ROWS];
    end

    logic [2:0]  col_s1_reg, row_s1_reg;
    logic [10:0] x_s1_reg, h_s1_reg;
    logic [9:0]  y_s1_reg, v_s1_reg;
    logic        in_grid_s1_reg;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            col_s1_reg     <= '0;
            row_s1_reg     <= '0;
            x_s1_reg       <= '0;
            y_s1_reg       <= '0;
            h_s1_reg       <= '0;
            v_s1_reg       <= '0;
            in_grid_s1_reg <= 1'b0;
            x_out          <= '0;
            y_out          <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
        end else begin
            col_s1_reg     <= col_c;
            row_s1_reg     <= row_c;
            x_s1_reg       <= x_c;
            y_s1_reg       <= y_c;
            h_s1_reg       <= hcount_in;
            v_s1_reg       <= vcount_in;
            in_grid_s1_reg <= in_grid_c;
            x_out          <= in_grid_s1_reg ? x_s1_reg : '0;
            y_out          <= in_grid_s1_reg ? y_s1_reg : '0;
            hcount_out     <= h_s1_reg;
            vcount_out     <= v_s1_reg;
        end
    end

    assign rd_idx_out  = IDX_W'(int'(row_s1_reg) * COLS + int'(col_s1_reg));
    assign in_grid_out = in_grid_s1_reg;

endmodule

// File: rtl/letter_grid_buffer.sv
// letter_grid_buffer: ROWS x COLS grid of typed letters.
// Keys arrive on key_bus (valid/ready); letters fill the current row,
// backspace erases, enter on a full row commits it (commit_valid_out pulse,
// commit_word_out holds the row, column 0 in the LSBs). clear_in wipes the
// grid one cell per cycle. The scan path returns, 2 cycles later, the letter
// and tile origin under (hcount_out, vcount_out).
// Ports: pixel_clk_in, rst_n_in (async active-low); key_bus (slave);
//        clear_in; hcount_in/vcount_in -> hcount_out/vcount_out, letter_out,
//        x_out, y_out; cursor_row_out/cursor_col_out; commit_valid_out,
//        commit_word_out; full_out.
module letter_grid_buffer
    import text_pkg::*;
#(
    parameter int COLS     = 5,
    parameter int ROWS     = 6,
    parameter int ORIGIN_X = 100,
    parameter int ORIGIN_Y = 50,
    parameter int PITCH_X  = 42,
    parameter int PITCH_Y  = 49
) (
    input  logic                  pixel_clk_in,
    input  logic                  rst_n_in,
    letter_grid_buffer_if.slave   key_bus,
    input  logic                  clear_in,
    input  logic [10:0]           hcount_in,
    input  logic [9:0]            vcount_in,
    output logic [10:0]           hcount_out,
    output logic [9:0]            vcount_out,
    output logic [4:0]            letter_out,
    output logic [10:0]           x_out,
    output logic [9:0]            y_out,
    output logic [2:0]            cursor_row_out,
    output logic [2:0]            cursor_col_out,
    output logic                  commit_valid_out,
    output logic [5*COLS-1:0]     commit_word_out,
    output logic                  full_out
);

    localparam int               CELLS    = ROWS * COLS;
    localparam int               IDX_W    = $clog2(CELLS);
    localparam logic [2:0]       COL_END  = 3'(COLS);
    localparam logic [2:0]       ROW_LAST = 3'(ROWS - 1);
    localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(CELLS - 1);

    function automatic logic [IDX_W-1:0] cell_index(input logic [2:0] r, input logic [2:0] c);
        return IDX_W'(int'(r) * COLS + int'(c));
    endfunction

    grid_state_t       state_reg, state_next;
    logic [IDX_W-1:0]  clr_idx_reg, clr_idx_next;
    logic [2:0]        row_reg, row_next, col_reg, col_next;
    // Copy of the row being edited, so a commit needs no array read port.
    logic [5*COLS-1:0] row_buf_reg, row_buf_next;
    logic [5*COLS-1:0] commit_word_reg, commit_word_next;
    logic              commit_valid_reg, commit_valid_next;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [4:0]        wr_data;
    logic              key_accept;

    assign key_bus.key_ready_out = (state_reg == EDIT);
    assign key_accept = key_bus.key_valid_in && key_bus.key_ready_out;

    always_comb begin
        state_next        = state_reg;
        clr_idx_next      = clr_idx_reg;
        row_next          = row_reg;
        col_next          = col_reg;
        row_buf_next      = row_buf_reg;
        commit_word_next  = commit_word_reg;
        commit_valid_next = 1'b0;
        wr_en             = 1'b0;
        wr_idx            = '0;
        wr_data           = LETTER_NONE;

        case (state_reg)
            CLEAR: begin
                wr_en  = 1'b1;
                wr_idx = clr_idx_reg;
                if (clr_idx_reg == CLR_LAST) begin
                    state_next = EDIT;
                end else begin
                    clr_idx_next = clr_idx_reg + 1'b1;
                end
            end
            EDIT: begin
                if (key_accept) begin
                    if (is_letter(key_bus.key_code_in) && (col_reg < COL_END)) begin
                        wr_en    = 1'b1;
                        wr_idx   = cell_index(row_reg, col_reg);
                        wr_data  = key_bus.key_code_in;
                        row_buf_next[int'(col_reg)*5 +: 5] = key_bus.key_code_in;
                        col_next = col_reg + 3'd1;
                    end else if ((key_bus.key_code_in == KEY_BACKSPACE) && (col_reg != 3'd0)) begin
                        wr_en    = 1'b1;
                        wr_idx   = cell_index(row_reg, col_reg - 3'd1);
                        row_buf_next[(int'(col_reg)-1)*5 +: 5] = LETTER_NONE;
                        col_next = col_reg - 3'd1;
                    end else if ((key_bus.key_code_in == KEY_ENTER) && (col_reg == COL_END)) begin
                        state_next = COMMIT;
                    end
                end
            end
            COMMIT: begin
                commit_valid_next = 1'b1;
                commit_word_next  = row_buf_reg;
                row_buf_next      = '0;
                if (row_reg == ROW_LAST) begin
                    state_next = DONE;
                end else begin
                    row_next   = row_reg + 3'd1;
                    col_next   = 3'd0;
                    state_next = EDIT;
                end
            end
            default: ;  // DONE: hold until clear or reset
        endcase

        // Clear overrides everything this cycle, including a key or a pending commit.
        if (clear_in) begin
            state_next        = CLEAR;
            clr_idx_next      = '0;
            row_next          = '0;
            col_next          = '0;
            row_buf_next      = '0;
            commit_word_next  = commit_word_reg;
            commit_valid_next = 1'b0;
            wr_en             = 1'b0;
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg        <= CLEAR;
            clr_idx_reg      <= '0;
            row_reg          <= '0;
            col_reg          <= '0;
            row_buf_reg      <= '0;
            commit_word_reg  <= '0;
            commit_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            clr_idx_reg      <= clr_idx_next;
            row_reg          <= row_next;
            col_reg          <= col_next;
            row_buf_reg      <= row_buf_next;
            commit_word_reg  <= commit_word_next;
            commit_valid_reg <= commit_valid_next;
        end
    end

    // Cell array: one write port, one registered read port (read-first).
    logic [4:0] cell_mem [CELLS];

    always_ff @(posedge pixel_clk_in) begin
        if (wr_en) cell_mem[wr_idx] <= wr_data;
    end

    logic [IDX_W-1:0] rd_idx;
    logic             rd_in_grid;

    letter_grid_scan #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .ORIGIN_X (ORIGIN_X),
        .ORIGIN_Y (ORIGIN_Y),
        .PITCH_X  (PITCH_X),
        .PITCH_Y  (PITCH_Y),
        .IDX_W    (IDX_W)
    ) u_scan (
        .pixel_clk_in (pixel_clk_in),
        .rst_n_in     (rst_n_in),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .rd_idx_out   (rd_idx),
        .in_grid_out  (rd_in_grid),
        .x_out        (x_out),
        .y_out        (y_out),
        .hcount_out   (hcount_out),
        .vcount_out   (vcount_out)
    );

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            letter_out <= LETTER_NONE;
        end else begin
            letter_out <= rd_in_grid ? cell_mem[rd_idx] : LETTER_NONE;
        end
    end

    assign cursor_row_out   = row_reg;
    assign cursor_col_out   = col_reg;
    assign commit_valid_out = commit_valid_reg;
    assign commit_word_out  = commit_word_reg;
    assign full_out         = (state_reg == DONE);

endmodule

// File: tb/tb_letter_grid_buffer.sv
module tb_letter_grid_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic [10:0] hcount_o;
    logic [9:0]  vcount_o;
    logic [4:0]  letter_o;
    logic [10:0] x_o;
    logic [9:0]  y_o;
    logic [2:0]  crow, ccol;
    logic        cvalid;
    logic [24:0] cword;
    logic        full;

    letter_grid_buffer_if kb ();

    letter_grid_buffer dut (
        .pixel_clk_in     (clk),
        .rst_n_in         (rst_n),
        .key_bus          (kb),
        .clear_in         (clear),
        .hcount_in        (hcount),
        .vcount_in        (vcount),
        .hcount_out       (hcount_o),
        .vcount_out       (vcount_o),
        .letter_out       (letter_o),
        .x_out            (x_o),
        .y_out            (y_o),
        .cursor_row_out   (crow),
        .cursor_col_out   (ccol),
        .commit_valid_out (cvalid),
        .commit_word_out  (cword),
        .full_out         (full)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int commits_seen = 0;

    typedef struct {
        logic [10:0] h;
        logic [9:0]  v;
        logic [4:0]  l;
        logic [10:0] x;
        logic [9:0]  y;
    } scan_exp_t;

    scan_exp_t   scan_q[$];
    logic [24:0] commit_q[$];

    logic scan_req = 1'b0;
    logic req_d1 = 1'b0, req_d2 = 1'b0;

    always @(posedge clk) begin
        req_d1 <= scan_req;
        req_d2 <= req_d1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("vec %0d %s = %0d", vectors, name, act);
        end
    endtask

    // Scan monitor: one tagged pixel emerges two edges after it was driven.
    always @(negedge clk) begin
        if (req_d2) begin
            if (scan_q.size() == 0) begin
                check("scan_queue_nonempty", 0, 1);
            end else begin
                scan_exp_t e;
                e = scan_q.pop_front();
                check("scan_hcount", 32'(hcount_o), 32'(e.h));
                check("scan_vcount", 32'(vcount_o), 32'(e.v));
                check("scan_letter", 32'(letter_o), 32'(e.l));
                check("scan_x", 32'(x_o), 32'(e.x));
                check("scan_y", 32'(y_o), 32'(e.y));
            end
        end
    end

    // Commit monitor: every pulse must match a queued expected word.
    always @(negedge clk) begin
        if (cvalid === 1'b1) begin
            commits_seen++;
            if (commit_q.size() == 0) begin
                check("unexpected_commit", 1, 0);
            end else begin
                logic [24:0] w;
                w = commit_q.pop_front();
                check("commit_word", 32'(cword), 32'(w));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (kb.key_ready_out !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("ready_timeout", 0, 1);
    endtask

    task automatic send_key(input logic [4:0] code);
        int n;
        wait_ready(n);
        kb.key_valid_in = 1'b1;
        kb.key_code_in  = code;
        tick();
        kb.key_valid_in = 1'b0;
        kb.key_code_in  = 5'd0;
    endtask

    task automatic scan(input int h, input int v, input int l, input int x, input int y);
        scan_exp_t e;
        e.h = 11'(h); e.v = 10'(v); e.l = 5'(l); e.x = 11'(x); e.y = 10'(y);
        scan_q.push_back(e);
        hcount   = 11'(h);
        vcount   = 10'(v);
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        hcount   = '0;
        vcount   = '0;
    endtask

    task automatic scan_all_blank();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 5; c++)
                scan(100 + 42*c, 50 + 49*r, 0, 100 + 42*c, 50 + 49*r);
        tick_n(3);
    endtask

    initial begin
        int n;
        int exp_commits;
        logic [24:0] w;
        logic [24:0] last_word;
        exp_commits = 0;
        kb.key_valid_in = 1'b0;
        kb.key_code_in  = 5'd0;

        // Reset values, with live scan inputs to show the delay line is held.
        hcount = 11'd150;
        vcount = 10'd60;
        tick_n(3);
        check("rst_ready", 32'(kb.key_ready_out), 0);
        check("rst_commit_valid", 32'(cvalid), 0);
        check("rst_commit_word", 32'(cword), 0);
        check("rst_full", 32'(full), 0);
        check("rst_letter", 32'(letter_o), 0);
        check("rst_x", 32'(x_o), 0);
        check("rst_y", 32'(y_o), 0);
        check("rst_hcount", 32'(hcount_o), 0);
        check("rst_vcount", 32'(vcount_o), 0);
        hcount = '0;
        vcount = '0;

        rst_n = 1'b1;
        wait_ready(n);
        check("clear_cycles_after_reset", 32'(n), 30);
        check("cursor_row_init", 32'(crow), 0);
        check("cursor_col_init", 32'(ccol), 0);
        scan_all_blank();

        // Backspace at column 0 and no-op codes leave the cursor alone.
        send_key(5'd27);
        send_key(5'd0);
        send_key(5'd30);
        check("bksp_col0", 32'(ccol), 0);

        // C, A, T
        send_key(5'd3);
        send_key(5'd1);
        send_key(5'd20);
        check("cat_col", 32'(ccol), 3);
        scan(100, 50, 3, 100, 50);
        scan(184, 60, 20, 184, 50);
        scan(141, 94, 3, 100, 50);   // gap pixel belongs to the tile on its left/top
        scan(142, 50, 1, 142, 50);
        scan(309, 343, 0, 268, 295); // last pixel inside the grid
        tick_n(3);

        // Backspace at col 3 clears cell 2.
        send_key(5'd27);
        check("bksp_col", 32'(ccol), 2);
        scan(184, 50, 0, 184, 50);
        tick_n(3);

        // Refill to 4 letters, Enter at col 4 does nothing.
        send_key(5'd20);
        send_key(5'd19);
        send_key(5'd28);
        tick_n(2);
        check("enter_col4_col", 32'(ccol), 4);
        check("enter_col4_row", 32'(crow), 0);
        send_key(5'd5);
        send_key(5'd9);              // row full: consumed, no effect
        check("full_row_col", 32'(ccol), 5);
        scan(268, 50, 5, 268, 50);
        tick_n(3);

        w = {5'd5, 5'd19, 5'd20, 5'd1, 5'd3};
        commit_q.push_back(w);
        exp_commits++;
        send_key(5'd28);
        tick_n(2);
        check("commit_count_row0", 32'(commits_seen), 32'(exp_commits));
        check("commit_cursor_row", 32'(crow), 1);
        check("commit_cursor_col", 32'(ccol), 0);

        // Rows 1..5.
        for (int r = 1; r < 6; r++) begin
            w = '0;
            for (int c = 0; c < 5; c++) begin
                logic [4:0] code;
                code = 5'(((r*5 + c) % 26) + 1);
                w[c*5 +: 5] = code;
                send_key(code);
            end
            commit_q.push_back(w);
            exp_commits++;
            last_word = w;
            send_key(5'd28);
            tick_n(2);
        end
        check("commit_count_all", 32'(commits_seen), 32'(exp_commits));
        check("done_full", 32'(full), 1);
        check("done_ready", 32'(kb.key_ready_out), 0);
        // Row 5 col 4 holds ((29 % 26) + 1) = 4.
        scan(268, 295, 4, 268, 295);
        tick_n(3);

        // A key held in DONE is not consumed.
        kb.key_valid_in = 1'b1;
        kb.key_code_in  = 5'd27;
        tick_n(5);
        check("done_hold_ready", 32'(kb.key_ready_out), 0);
        check("done_hold_col", 32'(ccol), 5);
        check("done_hold_row", 32'(crow), 5);
        kb.key_valid_in = 1'b0;

        // Clear wipes everything.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_full", 32'(full), 0);
        check("clear_cursor_row", 32'(crow), 0);
        wait_ready(n);
        check("clear_cycles", 32'(n), 30);
        check("clear_cursor_col", 32'(ccol), 0);
        check("clear_commit_word_held", 32'(cword), 32'(last_word));
        scan_all_blank();

        // Outside the grid.
        scan(90, 40, 0, 0, 0);
        scan(310, 50, 0, 0, 0);
        scan(100, 344, 0, 0, 0);
        scan(99, 100, 0, 0, 0);
        tick_n(3);

        // clear_in wins over a key in the same cycle.
        kb.key_valid_in = 1'b1;
        kb.key_code_in  = 5'd7;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        kb.key_valid_in = 1'b0;
        wait_ready(n);
        check("clear_vs_key_cycles", 32'(n), 30);
        check("clear_vs_key_col", 32'(ccol), 0);
        scan(100, 50, 0, 100, 50);
        tick_n(3);

        // Reset during COMMIT: no pulse, sweep restarts.
        for (int c = 0; c < 5; c++) send_key(5'(c + 10));
        kb.key_valid_in = 1'b1;
        kb.key_code_in  = 5'd28;
        tick();                      // now in COMMIT
        kb.key_valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midcommit_rst_ready", 32'(kb.key_ready_out), 0);
        check("midcommit_rst_word", 32'(cword), 0);
        tick_n(2);
        rst_n = 1'b1;
        wait_ready(n);
        check("midcommit_clear_cycles", 32'(n), 30);
        check("midcommit_cursor_col", 32'(ccol), 0);
        check("midcommit_commit_count", 32'(commits_seen), 32'(exp_commits));
        tick_n(4);
        check("scan_queue_drained", 32'(scan_q.size()), 0);
        check("commit_queue_drained", 32'(commit_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
